// File: rtl/quiz_scheduler_pkg.sv
// Shared state encoding, LFSR seed and default game parameters.
package fpsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_QUIZ = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned DEF_MAX_LIVES    = 3;
  localparam int unsigned DEF_QUIZ_TARGET  = 9;
  localparam int unsigned DEF_QUIZ_TIMEOUT = 8;
  localparam int unsigned DEF_MIN_GAP      = 4;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

endpackage

// File: rtl/quiz_scheduler_if.sv
// Control, answer and status bundle between the game controller and the scheduler.
interface quiz_scheduler_if;
  logic       Tick;
  logic       Enable;
  logic       Clear;
  logic       Ans_Valid;
  logic [1:0] Ans;
  logic       q_IDLE;
  logic       q_WAIT;
  logic       q_QUIZ;
  logic       q_DONE;
  logic [1:0] Quiz_Key;
  logic [3:0] Time_Left;
  logic [2:0] lives;
  logic [3:0] quiz_cnt;
  logic       Win;
  logic       Lose;

  modport master (
    output Tick, Enable, Clear, Ans_Valid, Ans,
    input  q_IDLE, q_WAIT, q_QUIZ, q_DONE, Quiz_Key, Time_Left,
    input  lives, quiz_cnt, Win, Lose
  );

  modport slave (
    input  Tick, Enable, Clear, Ans_Valid, Ans,
    output q_IDLE, q_WAIT, q_QUIZ, q_DONE, Quiz_Key, Time_Left,
    output lives, quiz_cnt, Win, Lose
  );
endinterface

// File: rtl/quiz_scheduler_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, seeded on reset.
module lfsr8
  import fpsr_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  output logic [7:0] q
);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) q <= LFSR_SEED;
    else       q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end

endmodule

// File: rtl/quiz_scheduler.sv
// Quiz game scheduler: random gaps between timed quizzes, lives and score tracking.
module quiz_scheduler
  import fpsr_pkg::*;
#(
  parameter int unsigned MAX_LIVES    = DEF_MAX_LIVES,
  parameter int unsigned QUIZ_TARGET  = DEF_QUIZ_TARGET,
  parameter int unsigned QUIZ_TIMEOUT = DEF_QUIZ_TIMEOUT,
  parameter int unsigned MIN_GAP      = DEF_MIN_GAP
) (
  input  logic            Clk,
  input  logic            Reset,
  quiz_scheduler_if.slave bus
);

  localparam logic [2:0] LIVES_INIT = 3'(MAX_LIVES);
  localparam logic [3:0] TARGET     = 4'(QUIZ_TARGET);
  localparam logic [3:0] TIMEOUT    = 4'(QUIZ_TIMEOUT);
  localparam logic [2:0] GAP_BASE   = 3'(MIN_GAP);

  state_t     state_q, state_d;
  logic [2:0] gap_q, gap_d;
  logic [3:0] tl_q, tl_d;
  logic [1:0] key_q, key_d;
  logic [2:0] lives_q, lives_d;
  logic [3:0] cnt_q, cnt_d;
  logic       win_q, win_d;
  logic       lose_q, lose_d;

  logic [7:0] lfsr;
  logic [2:0] gap_new;
  logic       quiz_end;
  logic [2:0] lives_upd;
  logic [3:0] cnt_upd;
  logic       lfsr_unused;

  lfsr8 u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .q     (lfsr)
  );

  assign gap_new     = GAP_BASE + {1'b0, lfsr[1:0]};
  assign lfsr_unused = ^lfsr[5:2];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      tl_q    <= '0;
      key_q   <= '0;
      lives_q <= LIVES_INIT;
      cnt_q   <= '0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      tl_q    <= tl_d;
      key_q   <= key_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    tl_d      = tl_q;
    key_d     = key_q;
    lives_d   = lives_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    lose_d    = lose_q;
    quiz_end  = 1'b0;
    lives_upd = lives_q;
    cnt_upd   = cnt_q;

    if (bus.Clear) begin
      state_d = ST_IDLE;
      gap_d   = '0;
      tl_d    = '0;
      key_d   = '0;
      lives_d = LIVES_INIT;
      cnt_d   = '0;
      win_d   = 1'b0;
      lose_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          lives_d = LIVES_INIT;
          cnt_d   = '0;
          if (bus.Enable) begin
            state_d = ST_WAIT;
            gap_d   = gap_new;
          end
        end
        ST_WAIT: begin
          if (bus.Enable && bus.Tick) begin
            if (gap_q == 3'd1) begin
              state_d = ST_QUIZ;
              gap_d   = '0;
              tl_d    = TIMEOUT;
              key_d   = lfsr[7:6];
            end else begin
              gap_d = gap_q - 3'd1;
            end
          end
        end
        ST_QUIZ: begin
          // An answer wins over a same-cycle Tick and is accepted even while paused
          if (bus.Ans_Valid) begin
            quiz_end = 1'b1;
            if (bus.Ans == key_q)
              cnt_upd = (cnt_q < TARGET) ? cnt_q + 4'd1 : cnt_q;
            else
              lives_upd = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
          end else if (bus.Enable && bus.Tick) begin
            if (tl_q == 4'd1) begin
              quiz_end  = 1'b1;
              lives_upd = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
            end else begin
              tl_d = tl_q - 4'd1;
            end
          end
          if (quiz_end) begin
            lives_d = lives_upd;
            cnt_d   = cnt_upd;
            tl_d    = '0;
            if (lives_upd == 3'd0) begin
              state_d = ST_DONE;
              lose_d  = 1'b1;
            end else if (cnt_upd == TARGET) begin
              state_d = ST_DONE;
              win_d   = 1'b1;
            end else begin
              state_d = ST_WAIT;
              gap_d   = gap_new;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.q_IDLE = (state_q == ST_IDLE);
    bus.q_WAIT = (state_q == ST_WAIT);
    bus.q_QUIZ = (state_q == ST_QUIZ);
    bus.q_DONE = (state_q == ST_DONE);
  end

  assign bus.Quiz_Key  = key_q;
  assign bus.Time_Left = tl_q;
  assign bus.lives     = lives_q;
  assign bus.quiz_cnt  = cnt_q;
  assign bus.Win       = win_q;
  assign bus.Lose      = lose_q;

endmodule

// File: tb/tb_quiz_scheduler.sv
// Directed table, hand sequences and random stimulus against a behavioural game model.
module tb_quiz_scheduler;

  localparam int MAX_LIVES    = 3;
  localparam int QUIZ_TARGET  = 9;
  localparam int QUIZ_TIMEOUT = 8;
  localparam int MIN_GAP      = 4;

  localparam int M_IDLE = 0, M_WAIT = 1, M_QUIZ = 2, M_DONE = 3;
  localparam int OP_RESET = 0, OP_ENABLE = 1, OP_TO_QUIZ = 2, OP_ANS_OK = 3;
  localparam int OP_ANS_BAD = 4, OP_TICKS = 5, OP_PAUSE = 6, OP_CLEAR = 7;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int checks = 0;
  int errors = 0;

  quiz_scheduler_if bus ();

  quiz_scheduler #(
    .MAX_LIVES    (MAX_LIVES),
    .QUIZ_TARGET  (QUIZ_TARGET),
    .QUIZ_TIMEOUT (QUIZ_TIMEOUT),
    .MIN_GAP      (MIN_GAP)
  ) u_dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // Behavioural model of the game
  int m_state, m_gap, m_tl, m_key, m_lives, m_cnt;
  bit m_win, m_lose;
  logic [7:0] m_lfsr;

  function automatic logic [7:0] lfsr_next(logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_gap = 0; m_tl = 0; m_key = 0;
    m_lives = MAX_LIVES; m_cnt = 0; m_win = 0; m_lose = 0;
    m_lfsr = 8'hA5;
  endtask

  task automatic model_step(bit tk, bit en, bit clr, bit av, int a);
    int nl = m_lives;
    int nc = m_cnt;
    bit ended = 0;
    int new_gap = MIN_GAP + (int'(m_lfsr) % 4);
    if (clr) begin
      m_state = M_IDLE; m_gap = 0; m_tl = 0; m_key = 0;
      m_lives = MAX_LIVES; m_cnt = 0; m_win = 0; m_lose = 0;
    end else if (m_state == M_IDLE) begin
      if (en) begin m_state = M_WAIT; m_gap = new_gap; end
    end else if (m_state == M_WAIT) begin
      if (en && tk) begin
        m_gap = m_gap - 1;
        if (m_gap == 0) begin
          m_state = M_QUIZ; m_tl = QUIZ_TIMEOUT; m_key = int'(m_lfsr) / 64;
        end
      end
    end else if (m_state == M_QUIZ) begin
      if (av) begin
        ended = 1;
        if (a == m_key) nc = (m_cnt + 1 > QUIZ_TARGET) ? QUIZ_TARGET : m_cnt + 1;
        else            nl = (m_lives > 0) ? m_lives - 1 : 0;
      end else if (en && tk) begin
        m_tl = m_tl - 1;
        if (m_tl == 0) begin ended = 1; nl = (m_lives > 0) ? m_lives - 1 : 0; end
      end
      if (ended) begin
        m_lives = nl; m_cnt = nc; m_tl = 0;
        if (nl == 0)                begin m_state = M_DONE; m_lose = 1; end
        else if (nc == QUIZ_TARGET) begin m_state = M_DONE; m_win = 1; end
        else                        begin m_state = M_WAIT; m_gap = new_gap; end
      end
    end
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic check_model(string name);
    logic [18:0] exp_v, act_v;
    exp_v = {m_state == M_IDLE, m_state == M_WAIT, m_state == M_QUIZ, m_state == M_DONE,
             2'(m_key), 4'(m_tl), 3'(m_lives), 4'(m_cnt), m_win, m_lose};
    act_v = {bus.q_IDLE, bus.q_WAIT, bus.q_QUIZ, bus.q_DONE, bus.Quiz_Key, bus.Time_Left,
             bus.lives, bus.quiz_cnt, bus.Win, bus.Lose};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (flags,key,tl,lives,cnt,win,lose) t=%0t",
               name, act_v, exp_v, $time);
    end
  endtask

  task automatic expect_fields(string name, logic [3:0] fl, int lv, int cn, int tl,
                               bit w, bit l);
    logic [15:0] exp_v, act_v;
    exp_v = {fl, 4'(tl), 3'(lv), 4'(cn), w, l};
    act_v = {bus.q_IDLE, bus.q_WAIT, bus.q_QUIZ, bus.q_DONE, bus.Time_Left,
             bus.lives, bus.quiz_cnt, bus.Win, bus.Lose};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h required %h (flags,tl,lives,cnt,win,lose)", name, act_v, exp_v);
    end
  endtask

  task automatic cycle(bit tk, bit en, bit clr, bit av, logic [1:0] a);
    bus.Tick = tk; bus.Enable = en; bus.Clear = clr; bus.Ans_Valid = av; bus.Ans = a;
    model_step(tk, en, clr, av, int'(a));
    @(posedge Clk);
    #1;
    check_model("cycle");
    bus.Tick = 1'b0; bus.Clear = 1'b0; bus.Ans_Valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.Tick = 0; bus.Enable = 0; bus.Clear = 0; bus.Ans_Valid = 0; bus.Ans = 0;
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    model_reset();
    expect_fields("reset", 4'b1000, MAX_LIVES, 0, 0, 0, 0);
    check_model("reset_model");
    Reset = 1'b0;
  endtask

  task automatic reset_async();
    #2;
    Reset = 1'b1;
    #1;
    model_reset();
    expect_fields("async_reset", 4'b1000, MAX_LIVES, 0, 0, 0, 0);
    checks++;
    if (bus.Quiz_Key !== 2'd0) begin
      errors++;
      $display("FAIL async_reset_key: got %0d required 0", bus.Quiz_Key);
    end
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  task automatic to_quiz();
    int n = 0;
    while (!bus.q_QUIZ && n < 20) begin
      cycle(1, 1, 0, 0, 2'd0);
      n++;
    end
    checks++;
    if (!bus.q_QUIZ || n < MIN_GAP || n > MIN_GAP + 3) begin
      errors++;
      $display("FAIL to_quiz: got %0d ticks (quiz=%0b) required %0d..%0d",
               n, bus.q_QUIZ, MIN_GAP, MIN_GAP + 3);
    end
  endtask

  task automatic run_op(int op, int arg);
    case (op)
      OP_RESET:   do_reset();
      OP_ENABLE:  cycle(0, 1, 0, 0, 2'd0);
      OP_TO_QUIZ: to_quiz();
      OP_ANS_OK:  cycle(0, 1, 0, 1, 2'(m_key));
      OP_ANS_BAD: cycle(0, 1, 0, 1, 2'(m_key + 1));
      OP_TICKS:   for (int i = 0; i < arg; i++) cycle(1, 1, 0, 0, 2'd0);
      OP_PAUSE:   for (int i = 0; i < arg; i++) cycle(1, 0, 0, 0, 2'd0);
      OP_CLEAR:   cycle(0, 1, 1, 0, 2'd0);
      default: ;
    endcase
  endtask

  typedef struct {
    int op; int arg; logic [3:0] fl; int lv; int cn; int tl; bit w; bit l;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{OP_RESET,   0,  4'b1000, 3, 0, 0, 0, 0};
    tbl[1]  = '{OP_ENABLE,  0,  4'b0100, 3, 0, 0, 0, 0};
    tbl[2]  = '{OP_TO_QUIZ, 0,  4'b0010, 3, 0, 8, 0, 0};
    tbl[3]  = '{OP_ANS_OK,  0,  4'b0100, 3, 1, 0, 0, 0};
    tbl[4]  = '{OP_TO_QUIZ, 0,  4'b0010, 3, 1, 8, 0, 0};
    tbl[5]  = '{OP_TICKS,   3,  4'b0010, 3, 1, 5, 0, 0};
    tbl[6]  = '{OP_PAUSE,   10, 4'b0010, 3, 1, 5, 0, 0};
    tbl[7]  = '{OP_TICKS,   5,  4'b0100, 2, 1, 0, 0, 0};
    tbl[8]  = '{OP_TO_QUIZ, 0,  4'b0010, 2, 1, 8, 0, 0};
    tbl[9]  = '{OP_ANS_BAD, 0,  4'b0100, 1, 1, 0, 0, 0};
    tbl[10] = '{OP_TO_QUIZ, 0,  4'b0010, 1, 1, 8, 0, 0};
    tbl[11] = '{OP_TICKS,   8,  4'b0001, 0, 1, 0, 0, 1};
    tbl[12] = '{OP_TICKS,   3,  4'b0001, 0, 1, 0, 0, 1};
    tbl[13] = '{OP_CLEAR,   0,  4'b1000, 3, 0, 0, 0, 0};
    tbl[14] = '{OP_ENABLE,  0,  4'b0100, 3, 0, 0, 0, 0};

    for (int i = 0; i < 15; i++) begin
      run_op(tbl[i].op, tbl[i].arg);
      expect_fields($sformatf("row%0d", i), tbl[i].fl, tbl[i].lv, tbl[i].cn, tbl[i].tl,
                    tbl[i].w, tbl[i].l);
    end

    // Nine correct answers, one racing the final Tick, plus a stray answer in WAIT
    do_reset();
    run_op(OP_ENABLE, 0);
    for (int q = 0; q < QUIZ_TARGET; q++) begin
      if (q == 2) begin
        cycle(0, 1, 0, 1, 2'd0);
        expect_fields("stray_ans", 4'b0100, 3, 2, 0, 0, 0);
      end
      to_quiz();
      if (q == 4) begin
        run_op(OP_TICKS, QUIZ_TIMEOUT - 1);
        expect_fields("tl_one", 4'b0010, 3, 4, 1, 0, 0);
        cycle(1, 1, 0, 1, 2'(m_key));
        expect_fields("ans_vs_tick", 4'b0100, 3, 5, 0, 0, 0);
      end else begin
        run_op(OP_ANS_OK, 0);
      end
    end
    expect_fields("win", 4'b0001, 3, 9, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 1, 2'(i));
    expect_fields("win_hold", 4'b0001, 3, 9, 0, 1, 0);
    run_op(OP_CLEAR, 0);
    expect_fields("win_clear", 4'b1000, 3, 0, 0, 0, 0);

    // Three wrong answers in a row lose the game
    run_op(OP_ENABLE, 0);
    for (int q = 0; q < 3; q++) begin
      to_quiz();
      run_op(OP_ANS_BAD, 0);
    end
    expect_fields("lose3", 4'b0001, 0, 0, 0, 0, 1);
    run_op(OP_CLEAR, 0);

    // Reset asserted asynchronously in the middle of a quiz
    run_op(OP_ENABLE, 0);
    to_quiz();
    run_op(OP_TICKS, 3);
    expect_fields("pre_reset", 4'b0010, 3, 0, 5, 0, 0);
    reset_async();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit tk, en, clr, av;
      logic [1:0] a;
      tk  = ($urandom % 3) == 0;
      en  = ($urandom % 8) != 0;
      clr = ($urandom % 250) == 0 || (m_state == M_DONE && ($urandom % 12) == 0);
      av  = ($urandom % 6) == 0;
      a   = ($urandom % 2) ? 2'(m_key) : 2'($urandom % 4);
      cycle(tk, en, clr, av, a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/quiz_scheduler.md
QUIZ_SCHEDULER -- requirements
Module: quiz_scheduler

Interface
REQ-001 Parameter: MAX_LIVES, 3, lives loaded on start (1..7).
REQ-002 Parameter: QUIZ_TARGET, 9, correct answers required to win (1..15).
REQ-003 Parameter: QUIZ_TIMEOUT, 8, ticks allowed per quiz (1..15).
REQ-004 Parameter: MIN_GAP, 4, minimum ticks between quizzes (1..4).
REQ-005 Port: Clk  in  1  system clock; the only clock in the block.
REQ-006 Port: Reset  in  1  asynchronous, active-high reset.
REQ-007 Port: Tick  in  1  one-cycle time-base pulse (~1 s), synchronous to Clk.
REQ-008 Port: Enable  in  1  level; game running; 0 pauses all counting.
REQ-009 Port: Clear  in  1  one-cycle pulse; return to IDLE from any state.
REQ-010 Port: Ans_Valid  in  1  one-cycle debounced answer strobe.
REQ-011 Port: Ans  in  2  answer index, sampled when Ans_Valid=1.
REQ-012 Port: q_IDLE, q_WAIT, q_QUIZ, q_DONE  out  1 each  one-hot state flags.
REQ-013 Port: Quiz_Key  out  2  expected answer for the active quiz.
REQ-014 Port: Time_Left  out  4  remaining ticks in the active quiz; 0 outside QUIZ.
REQ-015 Port: lives  out  3  remaining lives.
REQ-016 Port: quiz_cnt  out  4  correct answers so far.
REQ-017 Port: Win, Lose  out  1 each  level, valid in DONE only; exactly one is high in DONE.

Function
REQ-018 The LFSR SHALL be 8-bit, polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5, advancing every Clk cycle regardless of state.
REQ-019 IDLE SHALL hold lives=MAX_LIVES and quiz_cnt=0; on Enable=1 it SHALL go to WAIT, loading gap=MIN_GAP+lfsr[1:0].
REQ-020 In WAIT, each Tick with Enable=1 SHALL decrement gap; a Tick when gap==1 SHALL enter QUIZ, loading Time_Left=QUIZ_TIMEOUT and Quiz_Key=lfsr[7:6].
REQ-021 In QUIZ, Ans_Valid with Ans==Quiz_Key SHALL increment quiz_cnt; a mismatch SHALL decrement lives; either SHALL end the quiz.
REQ-022 In QUIZ, each Tick with Enable=1 SHALL decrement Time_Left; a Tick when Time_Left==1 SHALL decrement lives and end the quiz.
REQ-023 Ans_Valid and Tick in the same cycle SHALL be resolved by the answer; the Tick is ignored.
REQ-024 On quiz end: if updated lives==0, go to DONE with Lose=1; else if updated quiz_cnt==QUIZ_TARGET, go to DONE with Win=1; else go to WAIT with a new gap per REQ-019.
REQ-025 Ans_Valid outside QUIZ SHALL be ignored; Tick outside WAIT and QUIZ SHALL be ignored.
REQ-026 Enable=0 SHALL freeze gap, Time_Left and state; answers in QUIZ SHALL still be accepted.
REQ-027 DONE SHALL hold all outputs until Clear; Clear in any state SHALL enter IDLE on the next edge and take priority over every other event.
REQ-028 lives SHALL never underflow and quiz_cnt SHALL never exceed QUIZ_TARGET.
REQ-029 State transitions and output updates SHALL occur on the Clk edge after the causing event (1-cycle latency, registered outputs).

Reset
REQ-030 Reset SHALL force: state=IDLE (q_IDLE=1, others 0), lives=MAX_LIVES, quiz_cnt=0, Time_Left=0, Quiz_Key=0, Win=Lose=0, gap=0, LFSR=8'hA5.

Structure
REQ-031 Package fpsr_pkg SHALL hold the state encoding and the default values of MAX_LIVES, QUIZ_TARGET, QUIZ_TIMEOUT and MIN_GAP.
REQ-032 The LFSR SHALL be the sub-module lfsr8 (Clk, Reset, 8-bit out); the FSM and counters stay in quiz_scheduler.

Verification
REQ-033 Reset, Enable=1, apply Ticks -> q_WAIT one cycle after Enable; q_QUIZ after 4..7 Ticks; Time_Left=8.
REQ-034 In QUIZ, Ans=Quiz_Key with Ans_Valid -> quiz_cnt 0->1, lives stays 3, q_WAIT next cycle.
REQ-035 In QUIZ, 8 Ticks with no answer -> lives 3->2 and q_WAIT; three wrong answers in successive quizzes -> lives=0, q_DONE, Lose=1.
REQ-036 Answer correctly 9 quizzes -> quiz_cnt=9, q_DONE, Win=1; then Clear -> q_IDLE, lives=3, quiz_cnt=0.
REQ-037 Ans_Valid correct and Tick in the same cycle with Time_Left=1 -> quiz_cnt increments and lives is unchanged.
REQ-038 Enable=0 during QUIZ with Time_Left=5, apply 10 Ticks -> Time_Left stays 5; assert Reset mid-QUIZ -> all outputs reach their REQ-030 values immediately.
